// File: rtl/omsp_spi_slave.sv
// SPI slave peripheral on the openMSP430 peripheral bus: one byte-wide shift
// channel with DATA/CNTRL/STATUS registers, all SPI pins resynchronised to mclk.
module omsp_spi_slave #(
  parameter logic [14:0] BASE_ADDR = 15'h0158,
  parameter int          DEC_WD    = 2
) (
  input  logic        mclk,
  input  logic        puc_rst_n,
  input  logic [13:0] per_addr,
  input  logic [15:0] per_din,
  input  logic        per_en,
  input  logic [1:0]  per_we,
  output logic [15:0] per_dout,
  input  logic        sck,
  input  logic        ss,
  input  logic        mosi,
  output logic        miso,
  output logic        miso_oe,
  output logic        irq_spi
);

  localparam int WA = DEC_WD - 1;

  // Bus access: a transfer is a single cycle with per_en high; per_we=0 is a
  // read (data valid combinationally), per_we[0]/[1] write the low/high byte.
  logic          reg_sel;
  logic [WA-1:0] word_off;
  logic          sel_w0, sel_w1;
  logic          data_wr, cntrl_wr, stat_wr, data_rd, any_rd;

  assign reg_sel  = per_en & (per_addr[13:WA] == BASE_ADDR[14:DEC_WD]);
  assign word_off = per_addr[WA-1:0];
  assign sel_w0   = reg_sel & (word_off == WA'(0));
  assign sel_w1   = reg_sel & (word_off == WA'(1));
  assign any_rd   = reg_sel & (per_we == 2'b00);
  assign data_rd  = sel_w0 & (per_we == 2'b00);
  assign data_wr  = sel_w0 & per_we[0];
  assign cntrl_wr = sel_w0 & per_we[1];
  assign stat_wr  = sel_w1 & per_we[0];

  logic [4:0] cntrl;
  logic [7:0] tx_buf, rx_data, tx_sh, rx_sh;
  logic [2:0] bit_cnt;
  logic       rx_full, tx_full, overrun;
  logic [1:0] sck_sync, ss_sync, mosi_sync;
  logic       sck_prev, active_d;

  logic cpol, cpha, en, rxie, txie;
  assign {txie, rxie, en, cpha, cpol} = cntrl;

  logic sck_s, ss_s, mosi_s, active;
  logic lead_edge, trail_edge, sample_edge, drive_edge, byte_load, byte_done;
  logic [7:0] rx_next;

  assign sck_s  = sck_sync[1];
  assign ss_s   = ss_sync[1];
  assign mosi_s = mosi_sync[1];
  assign active = en & ~ss_s;

  assign lead_edge   = active & (sck_prev == cpol) & (sck_s != cpol);
  assign trail_edge  = active & (sck_prev != cpol) & (sck_s == cpol);
  assign sample_edge = cpha ? trail_edge : lead_edge;
  assign drive_edge  = cpha ? lead_edge  : trail_edge;
  // cpha=0 needs bit 7 on miso before the first edge, so load on selection.
  assign byte_load   = (active & ~active_d & ~cpha) | (drive_edge & (bit_cnt == 3'd0));
  assign byte_done   = sample_edge & (bit_cnt == 3'd7);
  assign rx_next     = {rx_sh[6:0], mosi_s};

  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      sck_sync  <= 2'b00;
      ss_sync   <= 2'b11;
      mosi_sync <= 2'b00;
      sck_prev  <= 1'b0;
      active_d  <= 1'b0;
      cntrl     <= '0;
      tx_buf    <= '0;
      rx_data   <= '0;
      tx_sh     <= '0;
      rx_sh     <= '0;
      bit_cnt   <= '0;
      rx_full   <= 1'b0;
      tx_full   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[0], sck};
      ss_sync   <= {ss_sync[0], ss};
      mosi_sync <= {mosi_sync[0], mosi};
      sck_prev  <= sck_s;
      active_d  <= active;

      if (!active) begin
        bit_cnt <= '0;
      end else if (sample_edge) begin
        rx_sh   <= rx_next;
        bit_cnt <= bit_cnt + 3'd1;
      end

      if (byte_load) begin
        tx_sh <= tx_full ? tx_buf : 8'h00;
        if (tx_full) tx_full <= 1'b0;
      end else if (drive_edge) begin
        tx_sh <= {tx_sh[6:0], 1'b0};
      end

      // Later assignments win: a bus write overrides the same-cycle load clear.
      if (data_wr) begin
        tx_buf  <= per_din[7:0];
        tx_full <= 1'b1;
      end
      if (cntrl_wr) cntrl <= per_din[12:8];

      if (data_rd) rx_full <= 1'b0;
      if (stat_wr && per_din[2]) overrun <= 1'b0;
      if (byte_done) begin
        rx_data <= rx_next;
        rx_full <= 1'b1;
        if (rx_full && !data_rd) overrun <= 1'b1;
      end
    end
  end

  always_comb begin
    per_dout = 16'h0000;
    if (any_rd && sel_w0) per_dout = {3'b000, cntrl, rx_data};
    if (any_rd && sel_w1) per_dout = {8'h00, 4'h0, active, overrun, tx_full, rx_full};
  end

  assign miso    = active & tx_sh[7];
  assign miso_oe = active;
  assign irq_spi = (rx_full & rxie) | (~tx_full & txie);

endmodule
